// File: rtl/motoro3_pwm_pkg.sv
// Shared constants, emit-select encoding and period clamp for the motoro3
// multi-channel PWM generator.
package motoro3_pwm_pkg;

    localparam int CH_DEF    = 3;
    localparam int CNT_W_DEF = 12;
    localparam int POS_W_DEF = 16;

    // What each channel does with its state on a given clock.
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_EMIT  = 2'd1,
        SEL_CLEAR = 2'd2
    } emit_sel_e;

    // Periods of 0 or 1 clock cannot hold a boundary; run them as 2.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len < 32'd2) ? 32'd2 : len;
    endfunction

endpackage

// File: rtl/motoro3_pwm_chan.sv
// One PWM channel: accumulates requested on-time, emits it once it reaches
// the minimum pulse width, and tracks want-vs-real for the loss report.
module motoro3_pwm_chan
    import motoro3_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic             clk,
    input  logic             nRst,
    input  emit_sel_e        i_sel,
    input  logic             i_flush,
    input  logic             i_capture,
    input  logic [CNT_W-1:0] i_len,
    input  logic [CNT_W-1:0] i_minOn,
    input  logic [POS_W-1:0] i_posWant,
    output logic             o_pwm,
    output logic [POS_W-1:0] o_remain,
    output logic [POS_W-1:0] o_lost
);

    logic [POS_W-1:0] r_remain;
    logic [POS_W-1:0] r_wantAcc;
    logic [POS_W-1:0] r_realAcc;
    logic [POS_W-1:0] r_lost;
    logic [CNT_W-1:0] r_onCnt;

    logic [POS_W:0]   w_sum;
    logic [POS_W:0]   w_len;
    logic [POS_W:0]   w_emit;
    logic [POS_W:0]   w_next;
    logic [POS_W-1:0] w_remSat;
    logic [POS_W-1:0] w_realNow;
    logic             w_fire;
    logic             w_pwm;

    assign w_sum    = {1'b0, r_remain} + {1'b0, i_posWant};
    assign w_len    = (POS_W+1)'(i_len);
    assign w_fire   = (w_sum >= (POS_W+1)'(i_minOn)) | i_flush;
    assign w_emit   = (w_sum > w_len) ? w_len : w_sum;
    assign w_next   = w_fire ? (w_sum - w_emit) : w_sum;
    assign w_remSat = w_next[POS_W] ? {POS_W{1'b1}} : w_next[POS_W-1:0];
    assign w_pwm    = (r_onCnt != '0);
    // Includes the clock in flight so a pulse cut by a step edge still counts.
    assign w_realNow = r_realAcc + POS_W'(w_pwm);

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_remain  <= '0;
            r_wantAcc <= '0;
            r_realAcc <= '0;
            r_lost    <= '0;
            r_onCnt   <= '0;
        end else begin
            case (i_sel)
                SEL_CLEAR: begin
                    r_remain  <= '0;
                    r_wantAcc <= '0;
                    r_realAcc <= '0;
                    r_onCnt   <= '0;
                    if (i_capture)
                        r_lost <= r_wantAcc - w_realNow;
                end
                SEL_EMIT: begin
                    r_remain  <= w_remSat;
                    r_onCnt   <= w_fire ? CNT_W'(w_emit) : '0;
                    r_wantAcc <= r_wantAcc + i_posWant;
                    r_realAcc <= w_realNow;
                end
                default: begin
                    if (w_pwm)
                        r_onCnt <= r_onCnt - CNT_W'(1);
                    r_realAcc <= w_realNow;
                end
            endcase
        end
    end

    assign o_pwm    = w_pwm;
    assign o_remain = r_remain;
    assign o_lost   = r_lost;

endmodule

// File: rtl/motoro3_pwm_multich_gen.sv
// Multi-channel motoro3 PWM generator: one shared period counter and flush
// flag driving CH minimum-pulse-width channels between sequencer and gates.
module motoro3_pwm_multich_gen
    import motoro3_pwm_pkg::*;
#(
    parameter int CH    = CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                pwmActive,
    input  logic [CNT_W-1:0]    m3r_pwmLenWant,
    input  logic [CNT_W-1:0]    m3r_pwmMinOn,
    input  logic                stepFirst,
    input  logic                stepLast,
    input  logic [CH*POS_W-1:0] posWant,
    output logic [CH-1:0]       pwm,
    output logic                periodTick,
    output logic [CH*POS_W-1:0] posRemain,
    output logic [CH*POS_W-1:0] posLost,
    output logic                lostValid
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_flush;
    logic             r_lostValid;

    logic [CNT_W-1:0] w_len;
    logic             w_tick;
    logic             w_capture;
    emit_sel_e        w_sel;

    assign w_len     = CNT_W'(clamp_len(32'(m3r_pwmLenWant)));
    assign w_tick    = pwmActive & (r_cnt == CNT_W'(1)) & ~stepFirst;
    assign w_capture = pwmActive & stepFirst;

    always_comb begin
        w_sel = SEL_HOLD;
        if (!pwmActive || stepFirst)
            w_sel = SEL_CLEAR;
        else if (w_tick)
            w_sel = SEL_EMIT;
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cnt <= w_len;
        end else if (!pwmActive || stepFirst || r_cnt == CNT_W'(1)) begin
            r_cnt <= w_len;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A stepLast landing on a tick sets the flag after that tick is evaluated.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_flush <= 1'b0;
        end else if (!pwmActive || stepFirst) begin
            r_flush <= 1'b0;
        end else if (stepLast) begin
            r_flush <= 1'b1;
        end else if (w_tick) begin
            r_flush <= 1'b0;
        end
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst)
            r_lostValid <= 1'b0;
        else
            r_lostValid <= w_capture;
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        motoro3_pwm_chan #(
            .CNT_W (CNT_W),
            .POS_W (POS_W)
        ) u_chan (
            .clk       (clk),
            .nRst      (nRst),
            .i_sel     (w_sel),
            .i_flush   (r_flush),
            .i_capture (w_capture),
            .i_len     (w_len),
            .i_minOn   (m3r_pwmMinOn),
            .i_posWant (posWant[g*POS_W +: POS_W]),
            .o_pwm     (pwm[g]),
            .o_remain  (posRemain[g*POS_W +: POS_W]),
            .o_lost    (posLost[g*POS_W +: POS_W])
        );
    end

    assign periodTick = w_tick;
    assign lostValid  = r_lostValid;

endmodule

// File: tb/tb_motoro3_pwm_multich_gen.sv
// Directed bench for motoro3_pwm_multich_gen: accumulate, clip/saturate,
// flush, loss report, collisions and channel independence.
module tb_motoro3_pwm_multich_gen;

    localparam int CH    = 3;
    localparam int CNT_W = 12;
    localparam int POS_W = 16;

    logic                clk = 1'b0;
    logic                nRst;
    logic                pwmActive;
    logic [CNT_W-1:0]    lenWant;
    logic [CNT_W-1:0]    minOn;
    logic                stepFirst;
    logic                stepLast;
    logic [CH*POS_W-1:0] posWant;
    logic [CH-1:0]       pwm;
    logic                periodTick;
    logic [CH*POS_W-1:0] posRemain;
    logic [CH*POS_W-1:0] posLost;
    logic                lostValid;

    int n_vec = 0;
    int n_err = 0;

    motoro3_pwm_multich_gen #(.CH(CH), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .pwmActive      (pwmActive),
        .m3r_pwmLenWant (lenWant),
        .m3r_pwmMinOn   (minOn),
        .stepFirst      (stepFirst),
        .stepLast       (stepLast),
        .posWant        (posWant),
        .pwm            (pwm),
        .periodTick     (periodTick),
        .posRemain      (posRemain),
        .posLost        (posLost),
        .lostValid      (lostValid)
    );

    // DUT acts on the falling edge; the bench drives and samples on the rising one.
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rem(input int k);
        return posRemain[k*POS_W +: POS_W];
    endfunction

    function automatic logic [15:0] lost(input int k);
        return posLost[k*POS_W +: POS_W];
    endfunction

    // Count high clocks per channel up to and including the next tick cycle,
    // then step past the tick edge.
    task automatic period(output int w0, output int w1, output int w2);
        int n;
        bit done;
        w0 = 0; w1 = 0; w2 = 0; n = 0; done = 0;
        while (!done) begin
            w0 += int'(pwm[0]);
            w1 += int'(pwm[1]);
            w2 += int'(pwm[2]);
            if (periodTick) begin
                done = 1;
            end else begin
                @(posedge clk);
                n++;
                if (n > 5000) begin
                    chk("tick_timeout", 64'(n), 64'(0));
                    done = 1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic restart(input int len, input int mo, input int p0, input int p1, input int p2);
        stepFirst = 0;
        stepLast  = 0;
        lenWant   = CNT_W'(len);
        minOn     = CNT_W'(mo);
        posWant   = {POS_W'(p2), POS_W'(p1), POS_W'(p0)};
        pwmActive = 0;
        repeat (2) @(posedge clk);
        pwmActive = 1;
    endtask

    int a, b, c, sa, sb, sc, n;

    initial begin
        nRst = 0; pwmActive = 0; stepFirst = 0; stepLast = 0;
        lenWant = 12'd100; minOn = 12'd32; posWant = '0;
        #10;
        chk("rst_pwm", 64'(pwm), 64'(0));
        chk("rst_tick", 64'(periodTick), 64'(0));
        chk("rst_remain", 64'(posRemain), 64'(0));
        chk("rst_lost", 64'(posLost), 64'(0));
        chk("rst_lvalid", 64'(lostValid), 64'(0));
        @(posedge clk);
        nRst = 1;

        // Accumulate 10/tick until 40 >= 32, then a 40-clock pulse.
        restart(100, 32, 10, 0, 0);
        period(a, b, c); chk("acc_rem1", 64'(rem(0)), 64'(10));
        period(a, b, c); chk("acc_w1", 64'(a), 64'(0)); chk("acc_rem2", 64'(rem(0)), 64'(20));
        period(a, b, c); chk("acc_w2", 64'(a), 64'(0)); chk("acc_rem3", 64'(rem(0)), 64'(30));
        period(a, b, c); chk("acc_w3", 64'(a), 64'(0)); chk("acc_rem4", 64'(rem(0)), 64'(0));
        period(a, b, c); chk("acc_w4", 64'(a), 64'(40)); chk("acc_rem5", 64'(rem(0)), 64'(10));

        // Clip to the period, carry the excess, saturate instead of wrapping.
        restart(100, 32, 150, 0, 0);
        period(a, b, c); chk("clip_rem1", 64'(rem(0)), 64'(50));
        period(a, b, c); chk("clip_w1", 64'(a), 64'(100)); chk("clip_rem2", 64'(rem(0)), 64'(100));
        period(a, b, c); chk("clip_w2", 64'(a), 64'(100)); chk("clip_rem3", 64'(rem(0)), 64'(150));
        posWant[15:0] = 16'hFFFF;
        period(a, b, c); chk("sat_rem4", 64'(rem(0)), 64'hFFFF);
        period(a, b, c); chk("sat_w4", 64'(a), 64'(100)); chk("sat_rem5", 64'(rem(0)), 64'hFFFF);

        // Flush emits the sub-minimum 30, then normal holding resumes.
        restart(100, 32, 10, 0, 0);
        period(a, b, c); chk("fl_rem1", 64'(rem(0)), 64'(10));
        period(a, b, c); chk("fl_rem2", 64'(rem(0)), 64'(20));
        stepLast = 1; @(posedge clk); stepLast = 0;
        period(a, b, c); chk("fl_rem3", 64'(rem(0)), 64'(0));
        period(a, b, c); chk("fl_w3", 64'(a), 64'(30)); chk("fl_rem4", 64'(rem(0)), 64'(10));

        // Loss: want 30+30+40 = 100, real 30+30 = 60.
        restart(40, 0, 30, 0, 0);
        period(a, b, c);
        period(a, b, c); chk("loss_w1", 64'(a), 64'(30));
        minOn = 12'd50; posWant[15:0] = 16'd40;
        period(a, b, c); chk("loss_w2", 64'(a), 64'(30)); chk("loss_rem", 64'(rem(0)), 64'(40));
        chk("loss_lv0", 64'(lostValid), 64'(0));
        stepFirst = 1; @(posedge clk); stepFirst = 0;
        chk("loss_lv1", 64'(lostValid), 64'(1));
        chk("loss_val", 64'(lost(0)), 64'(40));
        chk("loss_ch1", 64'(lost(1)), 64'(0));
        chk("loss_clr", 64'(rem(0)), 64'(0));
        @(posedge clk);
        chk("loss_lv2", 64'(lostValid), 64'(0));

        // Reversed loss via wrap: want 0xFFFF+51 -> 50, real 60 -> 0xFFF6.
        // stepFirst lands on the cnt==1 clock: it wins, nothing is emitted.
        restart(30, 0, 16'hFFFF, 0, 0);
        period(a, b, c); chk("rev_rem1", 64'(rem(0)), 64'hFFE1);
        posWant[15:0] = 16'd51;
        period(a, b, c); chk("rev_w1", 64'(a), 64'(30)); chk("rev_rem2", 64'(rem(0)), 64'hFFF6);
        n = 0;
        while (!periodTick && n < 1000) begin @(posedge clk); n++; end
        chk("col_found", 64'(periodTick), 64'(1));
        stepFirst = 1; @(posedge clk); stepFirst = 0;
        chk("col_pwm", 64'(pwm), 64'(0));
        chk("col_rem", 64'(rem(0)), 64'(0));
        chk("col_lv", 64'(lostValid), 64'(1));
        chk("rev_lost", 64'(lost(0)), 64'hFFF6);
        n = 1;
        while (!periodTick && n < 1000) begin @(posedge clk); n++; end
        chk("col_reload", 64'(n), 64'(30));

        // pwmActive dropped mid-pulse.
        restart(100, 0, 150, 0, 0);
        period(a, b, c);
        repeat (5) @(posedge clk);
        chk("act_pwm1", 64'(pwm[0]), 64'(1));
        chk("act_rem1", 64'(rem(0)), 64'(50));
        pwmActive = 0;
        @(posedge clk);
        chk("act_pwm0", 64'(pwm), 64'(0));
        chk("act_rem0", 64'(rem(0)), 64'(0));
        chk("act_tick", 64'(periodTick), 64'(0));
        chk("act_hold", 64'(lost(0)), 64'hFFF6);

        // Channel independence over 8 periods: ch0 2x40, ch1 8x40, ch2 none.
        restart(100, 32, 10, 40, 0);
        period(a, b, c);
        sa = 0; sb = 0; sc = 0;
        for (int i = 0; i < 8; i++) begin
            period(a, b, c);
            sa += a; sb += b; sc += c;
        end
        chk("ind_ch0", 64'(sa), 64'(80));
        chk("ind_ch1", 64'(sb), 64'(320));
        chk("ind_ch2", 64'(sc), 64'(0));
        repeat (3) @(posedge clk);
        chk("ind_mid", 64'(pwm), 64'(3'b010));

        // Asynchronous reset mid-pulse.
        #10 nRst = 0;
        #1;
        chk("arst_pwm", 64'(pwm), 64'(0));
        chk("arst_rem", 64'(posRemain), 64'(0));
        chk("arst_lost", 64'(posLost), 64'(0));
        chk("arst_lv", 64'(lostValid), 64'(0));
        chk("arst_tick", 64'(periodTick), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motoro3_pwm_multich_gen.md
Name: motoro3_pwm_multich_gen

Overview:
- Parametrised, multi-channel successor to the single-channel motoro3 PWM generator.
- One shared period counter drives CH independent channels. Each channel accumulates its requested on-time ("pos") per PWM period and emits it only once it reaches a programmable minimum pulse width, so MOSFET drivers never see sub-minimum pulses.
- Adds a flush-on-last-period mode and per-channel want-vs-real loss reporting.
- Sits between the step sequencer (step first/last pulses, per-phase pos requests) and the MOS gate drivers.

Parameters:
- CH, 3, number of PWM channels (motor phases).
- CNT_W, 12, period counter and minimum-pulse width.
- POS_W, 16, width of pos requests, remainders and accumulators.

Ports:
- clk  in  1  system clock (10 MHz); all state updates on the falling edge, as in the rest of motoro3.
- nRst  in  1  asynchronous active-low reset.
- pwmActive  in  1  block enable; low = idle/clear.
- m3r_pwmLenWant  in  CNT_W  PWM period in clocks; values 0 and 1 are treated as 2.
- m3r_pwmMinOn  in  CNT_W  minimum emitted pulse width in clocks.
- stepFirst  in  1  one-clock pulse at the start of a commutation step.
- stepLast  in  1  one-clock pulse; arms the flush for the next period boundary.
- posWant  in  CH*POS_W  per-channel on-time requested per period; channel k occupies bits [k*POS_W +: POS_W].
- pwm  out  CH  gate drive, high = MOS on.
- periodTick  out  1  high for one clock at each period boundary.
- posRemain  out  CH*POS_W  per-channel undelivered on-time.
- posLost  out  CH*POS_W  per-channel (want − real) of the previous step, two's complement.
- lostValid  out  1  one-clock pulse when posLost updates.

Behaviour:
- Reset (nRst low): all outputs 0; counter = clamped lenWant; remainders, on-counters, accumulators and flush flag = 0.
- pwmActive low:
  - Counter held at clamped lenWant; periodTick = 0.
  - pwm = 0 on the next clock edge.
  - remain, onCnt, wantAcc, realAcc and flush flag cleared.
  - posLost is held.
- Period counter, priority order:
  1. stepFirst → reload lenWant.
  2. cnt == 1 → reload lenWant.
  3. Otherwise decrement.
- periodTick = pwmActive & (cnt == 1) & !stepFirst.
- Per channel, on periodTick:
  - sum = remain + posWant, computed at POS_W+1 bits.
  - If sum ≥ minOn or flush is set: emit = min(sum, lenWant); onCnt <= emit; remain <= sum − emit.
  - Otherwise: remain <= sum, saturating at all-ones.
  - wantAcc += posWant (wraps at POS_W).
- Pulse output: pwm[k] = (onCnt[k] != 0). onCnt decrements every clock while nonzero.
  - A pulse starts the clock after the tick and lasts exactly emit clocks.
  - Because emit ≤ lenWant, the pulse always finishes before the next tick.
  - If lenWant changes mid-period, the next tick reloads onCnt regardless of its current value.
- realAcc[k] increments every clock pwm[k] is high (wraps).
- Flush flag:
  - Set by stepLast; cleared at the next periodTick after being applied.
  - stepLast coincident with periodTick: the flag applies from the following tick.
  - With flush set and minOn = 0, behaviour is identical to the normal path.
- stepFirst (pwmActive high):
  - posLost <= wantAcc − realAcc, for all channels; lostValid = 1 the following clock.
  - remain, onCnt, wantAcc, realAcc and flush flag cleared; pwm low next edge.
  - stepFirst coincident with periodTick: stepFirst wins and there is no emission.
- minOn = 0: every tick emits min(sum, lenWant).
- posWant = 0 with remain 0: no pulse.

Decomposition:
- Package motoro3_pwm_pkg holds:
  - default parameter constants;
  - the emit-select encoding (HOLD, EMIT, CLEAR);
  - the clamp function for lenWant.
- Sub-module motoro3_pwm_chan, instantiated CH times via generate. It owns remain, onCnt, wantAcc, realAcc and pwm for one channel.
- The top level owns the period counter, flush flag, lostValid and signal fan-out.

Test Plan:
1. Accumulate-then-emit. lenWant = 100, minOn = 32, posWant = 10 on channel 0.
   - remain is 10, 20, 30 after ticks 1–3 with no pwm.
   - Tick 4 emits 40: pwm high exactly 40 clocks; remain = 0.
2. Clip and carry. posWant = 150, lenWant = 100, minOn = 32.
   - Each tick emits 100 and remain grows 50, 100, 150, …
   - Drive long enough to confirm the remain saturates at 0xFFFF and never wraps.
3. Flush. lenWant = 100, minOn = 32, posWant = 10, remain = 20, then pulse stepLast.
   - The next tick emits 30; remain = 0; the flush flag clears.
   - The tick after that holds (remain = 10).
4. Loss report. Over one step, want = 100 and real = 60.
   - At stepFirst: posLost = 40 and lostValid pulses once.
   - A reversed case (want 50, real 60) reports 0xFFF6.
5. Collisions.
   - stepFirst on the same clock as cnt == 1: no emission, counter reloads, accumulators clear.
   - pwmActive dropped mid-pulse: pwm low next edge, remain = 0.
6. Channel independence (CH = 3, distinct posWant 10, 40, 0 with minOn = 32).
   - Channel 1 emits every tick.
   - Channel 0 emits every 4th tick.
   - Channel 2 stays low.
   - Async nRst asserted mid-pulse: all outputs 0 immediately.
